// File: rtl/dm1_3_buf.sv
// ============================================================================
// Module   : dm1_3_buf
// Brief    : 1:3 buffered demux, one-entry valid/ack holding register per
//            channel; select 3 is dropped and flagged on a sticky err.
//            Optional macro DM1_3_ERRCNT_EN adds a saturating err_cnt output.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dm1_3_buf #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i,
  input  logic [1:0]       s,
  input  logic             i_valid,
  output logic             i_ready,
  output logic [WIDTH-1:0] o0,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  output logic [2:0]       o_valid,
  input  logic [2:0]       o_ack,
  output logic             err,
`ifdef DM1_3_ERRCNT_EN
  output logic [7:0]       err_cnt,
`endif
  input  logic             err_clr
);

  localparam logic [1:0] C_SEL_ILLEGAL = 2'd3;

  logic [WIDTH-1:0] r_data [3];
  logic [2:0]       r_valid;
  logic             r_err;
  logic [3:0]       w_slot_free;
  logic             w_accept;
  logic             w_illegal;

  // Slot 3 is the illegal select: always "free" so the word is consumed.
  assign w_slot_free = {1'b1, ~r_valid | o_ack};
  assign i_ready     = w_slot_free[s];
  assign w_accept    = i_valid & i_ready;
  assign w_illegal   = w_accept & (s == C_SEL_ILLEGAL);

  for (genvar k = 0; k < 3; k++) begin : g_ch
    logic w_load;
    assign w_load = w_accept & (s == 2'(k));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_data[k]  <= '0;
        r_valid[k] <= 1'b0;
      end else begin
        // A load in the same cycle as a drain keeps the slot full.
        if (w_load) begin
          r_data[k]  <= i;
          r_valid[k] <= 1'b1;
        end else if (o_ack[k]) begin
          r_valid[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_illegal) begin
      r_err <= 1'b1;
    end else if (err_clr) begin
      r_err <= 1'b0;
    end
  end

`ifdef DM1_3_ERRCNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (err_clr) begin
      r_err_cnt <= {7'd0, w_illegal};
    end else if (w_illegal && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign err_cnt = r_err_cnt;
`endif

  assign o0      = r_data[0];
  assign o1      = r_data[1];
  assign o2      = r_data[2];
  assign o_valid = r_valid;
  assign err     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_dm1_3_buf.sv
// ============================================================================
// Module   : tb_dm1_3_buf
// Brief    : directed + random checks of dm1_3_buf against a rule-level model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dm1_3_buf;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] i = '0;
  logic [1:0]   s = '0;
  logic         i_valid = 1'b0;
  logic         i_ready;
  logic [W-1:0] o0, o1, o2;
  logic [2:0]   o_valid;
  logic [2:0]   o_ack = '0;
  logic         err;
  logic         err_clr = 1'b0;
`ifdef DM1_3_ERRCNT_EN
  logic [7:0]   err_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // Reference state: what each consumer should currently see.
  logic [W-1:0] m_d [3];
  logic [2:0]   m_v;
  logic         m_err;
  int           m_cnt;

  dm1_3_buf #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .i(i), .s(s), .i_valid(i_valid),
    .i_ready(i_ready), .o0(o0), .o1(o1), .o2(o2), .o_valid(o_valid),
    .o_ack(o_ack), .err(err),
`ifdef DM1_3_ERRCNT_EN
    .err_cnt(err_cnt),
`endif
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) m_d[k] = '0;
    m_v   = '0;
    m_err = 1'b0;
    m_cnt = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".o_valid"}, 32'(o_valid), 32'(m_v));
    chk({tag, ".o0"}, 32'(o0), 32'(m_d[0]));
    chk({tag, ".o1"}, 32'(o1), 32'(m_d[1]));
    chk({tag, ".o2"}, 32'(o2), 32'(m_d[2]));
    chk({tag, ".err"}, 32'(err), 32'(m_err));
`ifdef DM1_3_ERRCNT_EN
    chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(m_cnt));
`endif
  endtask

  // One clock of stimulus: drive after negedge, check ready, advance model at posedge.
  task automatic cyc(input string tag, input logic [W-1:0] di, input logic [1:0] ds,
                     input logic dv, input logic [2:0] da, input logic dc);
    logic rdy, acc;
    @(negedge clk);
    i = di; s = ds; i_valid = dv; o_ack = da; err_clr = dc;
    #1;
    if (ds == 2'd3) rdy = 1'b1;
    else            rdy = !m_v[ds] || da[ds];
    chk({tag, ".i_ready"}, 32'(i_ready), 32'(rdy));
    @(posedge clk);
    acc = dv && rdy;
    for (int k = 0; k < 3; k++) if (m_v[k] && da[k]) m_v[k] = 1'b0;
    if (acc && ds != 2'd3) begin
      m_d[ds] = di;
      m_v[ds] = 1'b1;
    end
    if (acc && ds == 2'd3) m_err = 1'b1;
    else if (dc)           m_err = 1'b0;
    if (dc)                          m_cnt = (acc && ds == 2'd3) ? 1 : 0;
    else if (acc && ds == 2'd3)      m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    @(negedge clk);
    i_valid = 1'b0; o_ack = '0; err_clr = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Async reset in the middle of a fill, with err set beforehand.
    cyc("t1_err", 4'hF, 2'd3, 1'b1, 3'b000, 1'b0);
    cyc("t1_fill", 4'hA, 2'd1, 1'b1, 3'b000, 1'b0);
    chk("t1.o1_loaded", 32'(o1), 32'hA);
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    chk("t1.o_valid_async", 32'(o_valid), 32'h0);
    chk("t1.o1_async", 32'(o1), 32'h0);
    chk("t1.err_async", 32'(err), 32'h0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;

    // Basic route then drain; word persists after drain.
    cyc("t2_route", 4'h5, 2'd2, 1'b1, 3'b000, 1'b0);
    chk("t2.o2", 32'(o2), 32'h5);
    chk("t2.o_valid", 32'(o_valid), 32'h4);
    cyc("t2_drain", 4'h0, 2'd0, 1'b0, 3'b100, 1'b0);
    chk("t2.o_valid_drained", 32'(o_valid), 32'h0);
    chk("t2.o2_held", 32'(o2), 32'h5);

    // Stall on full channel 0, other channel still flows.
    cyc("t3_fill", 4'h3, 2'd0, 1'b1, 3'b000, 1'b0);
    cyc("t3_stall", 4'h7, 2'd0, 1'b1, 3'b000, 1'b0);
    chk("t3.o0_held", 32'(o0), 32'h3);
    cyc("t3_other", 4'h7, 2'd1, 1'b1, 3'b000, 1'b0);
    chk("t3.o1", 32'(o1), 32'h7);

    // Drain and refill channel 0 in one cycle; stray ack on empty ch2.
    cyc("t4_refill", 4'h9, 2'd0, 1'b1, 3'b101, 1'b0);
    chk("t4.o0", 32'(o0), 32'h9);
    chk("t4.o_valid0", 32'(o_valid[0]), 32'h1);

    // Illegal select, set-beats-clear, then clear alone.
    cyc("t5_illegal", 4'hF, 2'd3, 1'b1, 3'b000, 1'b0);
    chk("t5.err", 32'(err), 32'h1);
    chk("t5.o_valid", 32'(o_valid), 32'h3);
    cyc("t5_setclr", 4'hF, 2'd3, 1'b1, 3'b000, 1'b1);
    chk("t5.err_setwins", 32'(err), 32'h1);
    cyc("t5_clr", 4'h0, 2'd0, 1'b0, 3'b000, 1'b1);
    chk("t5.err_cleared", 32'(err), 32'h0);

`ifdef DM1_3_ERRCNT_EN
    cyc("t6_pre", 4'h0, 2'd0, 1'b0, 3'b000, 1'b1);
    for (int n = 0; n < 256; n++) cyc("t6_sat", W'(n), 2'd3, 1'b1, 3'b000, 1'b0);
    chk("t6.err_cnt_sat", 32'(err_cnt), 32'hFF);
    cyc("t6_clr", 4'h0, 2'd0, 1'b0, 3'b000, 1'b1);
    chk("t6.err_cnt_clr", 32'(err_cnt), 32'h0);
`endif

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      cyc("rand", W'($urandom), 2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
          3'($urandom), ($urandom_range(0, 15) == 0));
    end

    idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
